// File: rtl/gen_for_pkg.sv
// Shared types and constants for the GenForEnt sum/difference link (encoder model and decoder).
package gen_for_pkg;

  typedef enum logic [1:0] {
    S_SUM = 2'd0,
    S_DIF = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam int CHK_INIT = 1;
  localparam int CHK_BIAS = 17;

endpackage

// File: rtl/gen_for_dec_if.sv
// Input word stream and output pair/checksum bundle of the sum/difference decoder.
interface gen_for_dec_if #(
  parameter int NBITS = 8
);
  logic [NBITS:0]   in_data;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] out_a;
  logic [NBITS-1:0] out_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             odd_err;
  logic [NBITS-1:0] chk;
  logic             chk_valid;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_valid, out_last, odd_err, chk, chk_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_valid, out_last, odd_err, chk, chk_valid
  );
endinterface

// File: rtl/gen_for_dec_solve.sv
// Solves S = A+B, D = A-B for (A, B); arithmetic wraps at NBITS+1 bits like the encoder's.
module sum_diff_solve #(
  parameter int NBITS = 8
) (
  input  logic        [NBITS:0]   i_s,
  input  logic signed [NBITS:0]   i_d,
  output logic        [NBITS-1:0] o_a,
  output logic        [NBITS-1:0] o_b,
  output logic                    o_odd
);
  logic [NBITS:0] w_p;
  logic [NBITS:0] w_q;

  assign w_p   = i_s + $unsigned(i_d);
  assign w_q   = i_s - $unsigned(i_d);
  // An odd P means S and D cannot come from one integer pair; halves are still emitted.
  assign o_a   = w_p[NBITS:1];
  assign o_b   = w_q[NBITS:1];
  assign o_odd = w_p[0];
endmodule

// File: rtl/gen_for_dec.sv
// Streaming sum/difference decoder: rebuilds (A, B) pairs and recomputes the per-frame checksum.
module gen_for_dec
  import gen_for_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int COUNT = 4
) (
  input logic          clk,
  input logic          rst_n,
  gen_for_dec_if.slave bus
);
  localparam int NPAIR = COUNT / 2;
  localparam int PCW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS:0]   r_sum;
  logic [PCW-1:0]   r_pair;
  logic [NBITS-1:0] r_acc;
  logic [NBITS-1:0] r_out_a;
  logic [NBITS-1:0] r_out_b;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_odd_err;
  logic [NBITS-1:0] r_chk;
  logic             r_chk_valid;

  logic             w_in_ready;
  logic             w_sum_xfer;
  logic             w_dif_xfer;
  logic             w_last_pair;
  logic [NBITS-1:0] w_word_lo;
  logic [NBITS-1:0] w_acc_sum;
  logic [NBITS-1:0] w_a;
  logic [NBITS-1:0] w_b;
  logic             w_odd;

  sum_diff_solve #(.NBITS(NBITS)) u_solve (
    .i_s   (r_sum),
    .i_d   ($signed(bus.in_data)),
    .o_a   (w_a),
    .o_b   (w_b),
    .o_odd (w_odd)
  );

  assign w_word_lo   = bus.in_data[NBITS-1:0];
  assign w_acc_sum   = r_acc + w_word_lo;
  assign w_last_pair = (r_pair == PCW'(NPAIR - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_sum_xfer  = 1'b0;
    w_dif_xfer  = 1'b0;
    case (r_state)
      S_SUM: begin
        w_in_ready = 1'b1;
        w_sum_xfer = bus.in_valid;
        if (bus.in_valid) w_state_nxt = S_DIF;
      end
      S_DIF: begin
        w_in_ready = 1'b1;
        w_dif_xfer = bus.in_valid;
        if (bus.in_valid) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) w_state_nxt = S_SUM;
      end
      default: w_state_nxt = S_SUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_SUM;
      r_sum       <= '0;
      r_pair      <= '0;
      r_acc       <= NBITS'(CHK_INIT);
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_odd_err   <= 1'b0;
      r_chk       <= '0;
      r_chk_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_chk_valid <= 1'b0;
      if (w_sum_xfer) begin
        r_sum <= bus.in_data;
        r_acc <= w_acc_sum;
      end
      if (w_dif_xfer) begin
        r_out_a     <= w_a;
        r_out_b     <= w_b;
        r_odd_err   <= w_odd;
        r_out_last  <= w_last_pair;
        r_out_valid <= 1'b1;
        // Frame close: publish the checksum and restart accumulation for the next frame.
        if (w_last_pair) begin
          r_chk       <= w_acc_sum - NBITS'(CHK_BIAS);
          r_chk_valid <= 1'b1;
          r_acc       <= NBITS'(CHK_INIT);
          r_pair      <= '0;
        end else begin
          r_acc  <= w_acc_sum;
          r_pair <= r_pair + PCW'(1);
        end
      end
      if (r_state == S_OUT && bus.out_ready) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.odd_err   = r_odd_err;
  assign bus.chk       = r_chk;
  assign bus.chk_valid = r_chk_valid;
endmodule
